hilo_mul_ctrl: RTL and testbench

Execute-stage controller that sequences the multi-cycle multiplier and owns the architectural HI/LO registers. It accepts MULT/MULTU/MTHI/MTLO requests from EX, issues operands to the multiplier over a valid/ready handshake and stalls the pipeline until the product is accepted. It discards in-flight products on flush and writes the 64-bit result into HI/LO. It sits between the EX-stage decode/forwarding logic and the multiplier instance.

---
 rtl/hilo_mul_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_hilo_mul_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mul_ctrl.sv
// HI/LO owner and multi-cycle multiplier sequencer for the EX stage.
// Optional HILO_MADD_EN adds MADD/MSUB accumulate into {HI,LO}.
module hilo_mul_ctrl #(
  parameter int unsigned DRAIN_MAX = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall_hilo,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        mul_valid,
  output logic        mul_sign,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_flush,
  input  logic        mul_res_valid,
  output logic        mul_res_ready,
  input  logic [63:0] mul_result
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd3;
  localparam logic [2:0] OP_MTLO  = 3'd4;
`ifdef HILO_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;
  localparam logic [1:0] ACC_NONE = 2'd0;
  localparam logic [1:0] ACC_ADD  = 2'd1;
  localparam logic [1:0] ACC_SUB  = 2'd2;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_BUSY  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic              sign_q, sign_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef HILO_MADD_EN
  logic [1:0]        acc_q, acc_d;
`endif

  logic op_mul_c, op_acc_c, op_mthi_c, op_mtlo_c;
  logic stall_c, ready_c, flush_c;

  // Op decode
  assign op_mul_c  = (req_op == OP_MULT) || (req_op == OP_MULTU);
  assign op_mthi_c = (req_op == OP_MTHI);
  assign op_mtlo_c = (req_op == OP_MTLO);
`ifdef HILO_MADD_EN
  assign op_acc_c  = (req_op == OP_MADD) || (req_op == OP_MSUB);
`else
  assign op_acc_c  = 1'b0;
`endif

  // Next-state, register updates and combinational handshake outputs
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    ready_c = 1'b0;
    flush_c = 1'b0;
`ifdef HILO_MADD_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          if (op_mthi_c) begin
            hi_d = src_a;
          end else if (op_mtlo_c) begin
            lo_d = src_a;
          end else if (op_mul_c || op_acc_c) begin
            a_d     = src_a;
            b_d     = src_b;
            sign_d  = (req_op != OP_MULTU);
            valid_d = 1'b1;
            stall_c = 1'b1;
            state_d = S_ISSUE;
`ifdef HILO_MADD_EN
            acc_d   = (req_op == OP_MADD) ? ACC_ADD :
                      (req_op == OP_MSUB) ? ACC_SUB : ACC_NONE;
`endif
          end
        end
      end
      S_ISSUE: begin
        stall_c = 1'b1;
        if (flush) begin
          flush_c = 1'b1;
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        stall_c = 1'b1;
        ready_c = 1'b1;
        if (flush) begin
          // A product accepted alongside the flush is simply dropped
          flush_c = 1'b1;
          cnt_d   = '0;
          state_d = mul_res_valid ? S_IDLE : S_DRAIN;
        end else if (mul_res_valid) begin
`ifdef HILO_MADD_EN
          case (acc_q)
            ACC_ADD: {hi_d, lo_d} = {hi_q, lo_q} + mul_result;
            ACC_SUB: {hi_d, lo_d} = {hi_q, lo_q} - mul_result;
            default: {hi_d, lo_d} = mul_result;
          endcase
`else
          {hi_d, lo_d} = mul_result;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        // Hold back any HI/LO op until the orphaned product is gone
        ready_c = 1'b1;
        stall_c = req_valid && (op_mul_c || op_acc_c || op_mthi_c || op_mtlo_c);
        cnt_d   = cnt_q + CNT_W'(1);
        if (mul_res_valid || (cnt_q == CNT_W'(DRAIN_MAX - 1))) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
`ifdef HILO_MADD_EN
      acc_q   <= ACC_NONE;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
`ifdef HILO_MADD_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign stall_hilo    = resetn && stall_c;
  assign mul_res_ready = resetn && ready_c;
  assign mul_flush     = resetn && flush_c;
  assign mul_valid     = valid_q;
  assign mul_sign      = sign_q;
  assign mul_a         = a_q;
  assign mul_b         = b_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Scoreboard bench for hilo_mul_ctrl; the bench plays EX and the multiplier.
module tb_hilo_mul_ctrl;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd3;
  localparam logic [2:0] OP_MTLO  = 3'd4;
  localparam logic [2:0] OP_MADD  = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        stall_hilo;
  logic [31:0] hi_o, lo_o;
  logic        mul_valid, mul_sign, mul_flush, mul_res_ready;
  logic [31:0] mul_a, mul_b;
  logic        mul_res_valid;
  logic [63:0] mul_result;

  int          checks = 0;
  int          failures = 0;
  int          issue_cnt = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  hilo_mul_ctrl #(.DRAIN_MAX(8), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
    .src_a(src_a), .src_b(src_b), .flush(flush), .stall_hilo(stall_hilo),
    .hi_o(hi_o), .lo_o(lo_o), .mul_valid(mul_valid), .mul_sign(mul_sign),
    .mul_a(mul_a), .mul_b(mul_b), .mul_flush(mul_flush),
    .mul_res_valid(mul_res_valid), .mul_res_ready(mul_res_ready),
    .mul_result(mul_result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (mul_valid === 1'b1) issue_cnt++;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = v;
    req_op    = op;
    src_a     = a;
    src_b     = b;
  endtask

  task automatic push_hilo(input logic [31:0] h, input logic [31:0] l);
    m_hi = h;
    m_lo = l;
    exp_q.push_back({h, l});
  endtask

  task automatic check_hilo(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {hi_o, lo_o}, e);
    end
  endtask

  function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [63:0] ea, eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // MTHI/MTLO or an ignored op: no stall, write visible after one edge
  task automatic move_op(input string tag, input logic [2:0] op, input logic [31:0] val, input logic fl);
    drive_req(1'b1, op, val, 32'd0);
    flush = fl;
    settle();
    check({tag, "_stall"}, stall_hilo, 1'b0);
    if (!fl && op == OP_MTHI) push_hilo(val, m_lo);
    else if (!fl && op == OP_MTLO) push_hilo(m_hi, val);
    else push_hilo(m_hi, m_lo);
    step();
    drive_req(1'b0, OP_NOP, 32'd0, 32'd0);
    flush = 1'b0;
    settle();
    check_hilo(tag);
    check({tag, "_noissue"}, mul_valid, 1'b0);
  endtask

  // Full multiply from IDLE; product returned lat cycles after issue
  task automatic run_mul(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat);
    logic [63:0] p, acc;
    logic        sgn;
    sgn = (op != OP_MULTU);
    p   = mul_model(a, b, sgn);
    acc = {m_hi, m_lo};
    if (op == OP_MADD)      acc = acc + p;
    else if (op == OP_MSUB) acc = acc - p;
    else                    acc = p;
    drive_req(1'b1, op, a, b);
    settle();
    check({tag, "_req_stall"}, stall_hilo, 1'b1);
    push_hilo(acc[63:32], acc[31:0]);
    issue_cnt = 0;
    step();
    check({tag, "_valid"}, mul_valid, 1'b1);
    check({tag, "_sign"}, mul_sign, sgn);
    check({tag, "_ops"}, {mul_a, mul_b}, {a, b});
    step();
    check({tag, "_busy_stall"}, stall_hilo, 1'b1);
    for (int i = 1; i < lat; i++) step();
    mul_res_valid = 1'b1;
    mul_result    = p;
    settle();
    check({tag, "_ready"}, mul_res_ready, 1'b1);
    step();
    mul_res_valid = 1'b0;
    mul_result    = 64'd0;
    settle();
    check({tag, "_done_stall"}, stall_hilo, 1'b0);
    check_hilo(tag);
    step();
    drive_req(1'b0, OP_NOP, 32'd0, 32'd0);
    settle();
    check({tag, "_issue_cnt"}, 64'(issue_cnt), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    resetn        = 1'b0;
    flush         = 1'b0;
    mul_res_valid = 1'b0;
    mul_result    = 64'd0;
    drive_req(1'b0, OP_NOP, 32'd0, 32'd0);

    settle();
    check("rst_stall", stall_hilo, 1'b0);
    check("rst_ready", mul_res_ready, 1'b0);
    step();
    step();
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    check("rst_valid", mul_valid, 1'b0);
    check("rst_flush", mul_flush, 1'b0);
    check("rst_ops", {mul_sign, mul_a, mul_b}, 65'd0);
    resetn = 1'b1;
    settle();
    check("idle_stall", stall_hilo, 1'b0);

    // Signed multiply, request held through DONE
    run_mul("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 3);
    check("mult_hi", hi_o, 32'hFFFF_FFFF);
    check("mult_lo", lo_o, 32'hFFFF_FFFA);

    move_op("mthi", OP_MTHI, 32'h1234_5678, 1'b0);
    move_op("mtlo", OP_MTLO, 32'h9ABC_DEF0, 1'b0);
    move_op("mthi_flushed", OP_MTHI, 32'hAAAA_5555, 1'b1);
    move_op("op7", 3'd7, 32'h5555_AAAA, 1'b0);
`ifndef HILO_MADD_EN
    move_op("madd_off", OP_MADD, 32'h0000_0002, 1'b0);
`endif

    // MULT killed by flush in IDLE
    drive_req(1'b1, OP_MULT, 32'd9, 32'd9);
    flush = 1'b1;
    settle();
    check("idle_flush_stall", stall_hilo, 1'b0);
    step();
    drive_req(1'b0, OP_NOP, 32'd0, 32'd0);
    flush = 1'b0;
    settle();
    check("idle_flush_noissue", mul_valid, 1'b0);

    // Flush in ISSUE, orphan arrives in DRAIN
    drive_req(1'b1, OP_MULT, 32'd4, 32'd4);
    settle();
    push_hilo(m_hi, m_lo);
    step();
    drive_req(1'b0, OP_NOP, 32'd0, 32'd0);
    flush = 1'b1;
    settle();
    check("issue_flush_pulse", mul_flush, 1'b1);
    step();
    flush = 1'b0;
    settle();
    check("issue_drain_ready", mul_res_ready, 1'b1);
    check("issue_drain_noflush", mul_flush, 1'b0);
    mul_res_valid = 1'b1;
    mul_result    = 64'd16;
    step();
    mul_res_valid = 1'b0;
    settle();
    check("issue_drain_exit", mul_res_ready, 1'b0);
    check_hilo("issue_orphan");

    // Flush in BUSY, orphan 2 cycles later, MULTU queued during DRAIN
    drive_req(1'b1, OP_MULT, 32'h1111_1111, 32'h10);
    settle();
    push_hilo(m_hi, m_lo);
    step();
    step();
    drive_req(1'b0, OP_NOP, 32'd0, 32'd0);
    flush = 1'b1;
    settle();
    check("busy_flush_pulse", mul_flush, 1'b1);
    step();
    flush = 1'b0;
    settle();
    check("drain_flush_low", mul_flush, 1'b0);
    drive_req(1'b1, OP_MULTU, 32'd5, 32'd7);
    settle();
    check("drain_req_stall", stall_hilo, 1'b1);
    step();
    mul_res_valid = 1'b1;
    mul_result    = 64'hDEAD_BEEF_0000_0001;
    settle();
    check("drain_ready", mul_res_ready, 1'b1);
    check("drain_stall2", stall_hilo, 1'b1);
    step();
    mul_res_valid = 1'b0;
    mul_result    = 64'd0;
    settle();
    check_hilo("busy_orphan");
    run_mul("multu", OP_MULTU, 32'd5, 32'd7, 1);
    check("multu_hilo", {hi_o, lo_o}, 64'd35);

    // Flush and product in the same BUSY cycle: straight back to IDLE
    drive_req(1'b1, OP_MULT, 32'd3, 32'd3);
    settle();
    push_hilo(m_hi, m_lo);
    step();
    step();
    drive_req(1'b0, OP_NOP, 32'd0, 32'd0);
    flush         = 1'b1;
    mul_res_valid = 1'b1;
    mul_result    = 64'd9;
    step();
    flush         = 1'b0;
    mul_res_valid = 1'b0;
    mul_result    = 64'd0;
    settle();
    check("flush_prod_idle", mul_res_ready, 1'b0);
    check_hilo("flush_prod_hilo");

    // Flush in BUSY, product never returns: DRAIN times out
    drive_req(1'b1, OP_MULT, 32'd6, 32'd6);
    settle();
    step();
    step();
    drive_req(1'b0, OP_NOP, 32'd0, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    settle();
    check("drain_nostall", stall_hilo, 1'b0);
    n = 0;
    while (mul_res_ready === 1'b1 && n < 20) begin
      n++;
      step();
    end
    check("drain_len", 64'(n), 64'd8);
    move_op("mtlo_after_drain", OP_MTLO, 32'd1, 1'b0);
    check("drain_lo", lo_o, 32'd1);

`ifdef HILO_MADD_EN
    move_op("madd_mthi", OP_MTHI, 32'd0, 1'b0);
    move_op("madd_mtlo", OP_MTLO, 32'd10, 1'b0);
    run_mul("msub1", OP_MSUB, 32'd2, 32'd3, 2);
    check("msub1_lo", lo_o, 32'd4);
    run_mul("msub2", OP_MSUB, 32'd2, 32'd3, 2);
    check("msub2_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_mul("madd1", OP_MADD, 32'hFFFF_FFFF, 32'd3, 1);
`endif

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
